// File: rtl/adc_capture_pkg.sv
// rtl/adc_capture_pkg.sv - shared types, field offsets and header packing for adc_capture_core
package adc_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    localparam int START_LSB = 0;
    localparam int COUNT_LSB = 64;
    localparam int DECIM_LSB = 80;

    localparam int HDR_TS_LSB    = 0;
    localparam int HDR_COUNT_LSB = 64;
    localparam int HDR_INDEX_LSB = 80;
    localparam int HDR_DECIM_LSB = 88;

    function automatic logic [127:0] make_header(
        input logic [63:0] ts,
        input logic [15:0] n,
        input logic [7:0]  idx,
        input logic [7:0]  decim
    );
        logic [127:0] h;
        h = '0;
        h[HDR_TS_LSB    +: 64] = ts;
        h[HDR_COUNT_LSB +: 16] = n;
        h[HDR_INDEX_LSB +: 8]  = idx;
        h[HDR_DECIM_LSB +: 8]  = decim;
        return h;
    endfunction

endpackage

// File: rtl/capture_fifo.sv
// rtl/capture_fifo.sv - synchronous first-word-fall-through FIFO for the capture buffer
module capture_fifo #(
    parameter int DATA_WIDTH = 128,
    parameter int FIFO_DEPTH = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]           wr_ptr_q;
    logic [AW:0]           rd_ptr_q;
    logic                  do_push;
    logic                  do_pop;

    // Extra pointer bit separates the wrapped-full case from empty.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/adc_capture_core.sv
// rtl/adc_capture_core.sv - timed ADC capture engine; ADC_CAPTURE_DECIMATE_EN enables beat decimation
module adc_capture_core
    import adc_capture_pkg::*;
#(
    parameter int INDEX      = 0,
    parameter int DATA_WIDTH = 128,
    parameter int FIFO_DEPTH = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  write,
    input  logic [127:0]          fifo_din,
    output logic                  cmd_full,
    input  logic [63:0]           counter,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  busy,
    output logic                  capture_done,
    output logic                  timestamp_error,
    output logic                  overflow_error
);
    state_e        state_q, state_d;
    logic [63:0]   start_q, start_d;
    logic [15:0]   count_q, count_d;
    logic [7:0]    decim_q, decim_d;
    logic [15:0]   beat_q, beat_d;
    logic [7:0]    skip_q, skip_d;
    logic          done_q, done_d;
    logic          ts_err_q, ts_err_d;
    logic          ovf_err_q, ovf_err_d;
    logic          tready_q;
    logic          push;
    logic [DATA_WIDTH-1:0] push_data;
    logic          fifo_full;
    logic [7:0]    cmd_decim;
    logic          unused_cmd_bits;

`ifdef ADC_CAPTURE_DECIMATE_EN
    assign cmd_decim       = fifo_din[DECIM_LSB +: 8];
    assign unused_cmd_bits = ^fifo_din[127:88];
`else
    // A decimation of zero keeps every beat and leaves the header field clear.
    assign cmd_decim       = 8'd0;
    assign unused_cmd_bits = ^fifo_din[127:80];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            start_q   <= '0;
            count_q   <= '0;
            decim_q   <= '0;
            beat_q    <= '0;
            skip_q    <= '0;
            done_q    <= 1'b0;
            ts_err_q  <= 1'b0;
            ovf_err_q <= 1'b0;
            tready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            count_q   <= count_d;
            decim_q   <= decim_d;
            beat_q    <= beat_d;
            skip_q    <= skip_d;
            done_q    <= done_d;
            ts_err_q  <= ts_err_d;
            ovf_err_q <= ovf_err_d;
            tready_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        start_d   = start_q;
        count_d   = count_q;
        decim_d   = decim_q;
        beat_d    = beat_q;
        skip_d    = skip_q;
        done_d    = 1'b0;
        ts_err_d  = ts_err_q;
        push      = 1'b0;
        push_data = s_axis_tdata;
        unique case (state_q)
            ST_IDLE: begin
                if (write) begin
                    if (fifo_din[START_LSB +: 64] > counter) begin
                        start_d = fifo_din[START_LSB +: 64];
                        count_d = fifo_din[COUNT_LSB +: 16];
                        decim_d = cmd_decim;
                        state_d = ST_ARMED;
                    end else begin
                        ts_err_d = 1'b1;
                    end
                end
            end
            ST_ARMED: begin
                if (counter == start_q) begin
                    push             = 1'b1;
                    push_data        = '0;
                    push_data[127:0] = make_header(counter, count_q, 8'(INDEX), decim_q);
                    beat_d           = '0;
                    skip_d           = '0;
                    if (count_q == 16'd0) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                if (s_axis_tvalid) begin
                    // Keep one beat, then skip decim_q beats; dropped pushes still count.
                    if (skip_q == 8'd0) begin
                        push   = 1'b1;
                        skip_d = decim_q;
                        beat_d = beat_q + 16'd1;
                        if (beat_d == count_q) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        skip_d = skip_q - 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d  = ST_IDLE;
            push     = 1'b0;
            done_d   = 1'b0;
            ts_err_d = ts_err_q;
        end
        ovf_err_d = ovf_err_q | (push & fifo_full);
    end

    capture_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (flush),
        .push_i     (push),
        .push_data_i(push_data),
        .pop_i      (read),
        .dout_o     (dout),
        .full_o     (fifo_full),
        .empty_o    (empty)
    );

    assign cmd_full        = (state_q != ST_IDLE);
    assign busy            = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
    assign capture_done    = done_q;
    assign timestamp_error = ts_err_q;
    assign overflow_error  = ovf_err_q;
    assign s_axis_tready   = tready_q;

endmodule

// File: tb/tb_adc_capture_core.sv
// tb/tb_adc_capture_core.sv - directed self-checking bench for adc_capture_core
module tb_adc_capture_core;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         flush = 1'b0;
    logic         write = 1'b0;
    logic [127:0] fifo_din = '0;
    logic         cmd_full;
    logic [63:0]  counter = '0;
    logic [127:0] s_axis_tdata = '0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tready;
    logic         read = 1'b0;
    logic [127:0] dout;
    logic         empty;
    logic         busy;
    logic         capture_done;
    logic         timestamp_error;
    logic         overflow_error;

    int checks = 0;
    int errors = 0;

    adc_capture_core #(.INDEX(5), .DATA_WIDTH(128), .FIFO_DEPTH(8)) dut (
        .clk(clk), .reset(reset), .flush(flush), .write(write), .fifo_din(fifo_din),
        .cmd_full(cmd_full), .counter(counter), .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .read(read),
        .dout(dout), .empty(empty), .busy(busy), .capture_done(capture_done),
        .timestamp_error(timestamp_error), .overflow_error(overflow_error)
    );

    always #5 clk = ~clk;

    // Time advances by one per clock; each beat carries 1000 + counter.
    task automatic tick();
        @(posedge clk);
        #1;
        counter      = counter + 64'd1;
        s_axis_tdata = {64'd0, counter + 64'd1000};
    endtask

    function automatic logic [127:0] hdr(input logic [63:0] ts, input logic [15:0] n, input logic [7:0] d);
        return {32'd0, d, 8'd5, n, ts};
    endfunction

    task automatic send_cmd(input logic [63:0] start, input logic [15:0] n, input logic [7:0] d);
        fifo_din = {40'hFF_FFFF_FFFF, d, n, start};
        write = 1'b1;
        tick();
        write = 1'b0;
    endtask

    task automatic drain(input logic [127:0] exp_words [$], input string name);
        foreach (exp_words[i]) begin
            checks++;
            if (empty !== 1'b0 || dout !== exp_words[i]) begin
                errors++;
                $display("FAIL %s_word%0d got %h empty=%b exp %h", name, i, dout, empty, exp_words[i]);
            end
            read = 1'b1;
            tick();
            read = 1'b0;
        end
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL %s_empty got %b exp 1", name, empty); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({cmd_full, busy, capture_done, timestamp_error, overflow_error, s_axis_tready} !== 6'b0) begin
            errors++; $display("FAIL rst_flags got %b exp 000000", {cmd_full, busy, capture_done, timestamp_error, overflow_error, s_axis_tready});
        end
        checks++;
        if (empty !== 1'b1 || dout !== 128'd0) begin
            errors++; $display("FAIL rst_fifo got empty=%b dout=%h exp empty=1 dout=0", empty, dout);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL rst_tready got %b exp 1", s_axis_tready); end
        read = 1'b1;
        tick();
        read = 1'b0;
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL rd_empty got %b exp 1", empty); end
    endtask

    task automatic test_basic();
        logic [127:0] exp_words [$];
        int pulses = 0;
        counter = 64'd100;
        s_axis_tvalid = 1'b1;
        send_cmd(64'd200, 16'd4, 8'd0);
        checks++;
        if (cmd_full !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL basic_latency got cmd_full=%b busy=%b exp 1 1", cmd_full, busy);
        end
        while (counter != 64'd200) tick();
        tick();
        checks++;
        if (empty !== 1'b0 || dout !== hdr(64'd200, 16'd4, 8'd0)) begin
            errors++; $display("FAIL basic_header got %h empty=%b exp %h", dout, empty, hdr(64'd200, 16'd4, 8'd0));
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (capture_done === 1'b1) pulses++;
        end
        checks++;
        if (capture_done !== 1'b1 || busy !== 1'b0 || cmd_full !== 1'b0) begin
            errors++; $display("FAIL basic_done got done=%b busy=%b cmd_full=%b exp 1 0 0", capture_done, busy, cmd_full);
        end
        s_axis_tvalid = 1'b0;
        tick();
        if (capture_done === 1'b1) pulses++;
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL basic_pulses got %0d exp 1", pulses); end
        exp_words = '{hdr(64'd200, 16'd4, 8'd0), 128'd1201, 128'd1202, 128'd1203, 128'd1204};
        drain(exp_words, "basic");
    endtask

    task automatic test_late();
        counter = 64'd500;
        send_cmd(64'd500, 16'd2, 8'd0);
        checks++;
        if (timestamp_error !== 1'b1 || cmd_full !== 1'b0 || busy !== 1'b0 || empty !== 1'b1) begin
            errors++; $display("FAIL late_cmd got err=%b cmd_full=%b busy=%b empty=%b exp 1 0 0 1", timestamp_error, cmd_full, busy, empty);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (timestamp_error !== 1'b0) begin errors++; $display("FAIL late_clear got %b exp 0", timestamp_error); end
    endtask

    task automatic test_gapped();
        logic [127:0] exp_words [$];
        logic pattern [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int done_at = -1;
        counter = 64'd700;
        s_axis_tvalid = 1'b0;
        send_cmd(64'd701, 16'd3, 8'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            s_axis_tvalid = pattern[i];
            tick();
            if (capture_done === 1'b1) done_at = i;
        end
        s_axis_tvalid = 1'b0;
        checks++;
        if (done_at != 4) begin errors++; $display("FAIL gap_done_cycle got %0d exp 4", done_at); end
        exp_words = '{hdr(64'd701, 16'd3, 8'd0), 128'd1702, 128'd1705, 128'd1706};
        drain(exp_words, "gap");
    endtask

    task automatic test_decimation();
        logic [127:0] exp_words [$];
        int pulses = 0;
        int done_at = -1;
        counter = 64'd5000;
        s_axis_tvalid = 1'b1;
        send_cmd(64'd5001, 16'd3, 8'd2);
        tick();
        for (int i = 0; i < 9; i++) begin
            tick();
            if (capture_done === 1'b1) begin pulses++; done_at = i; end
        end
        s_axis_tvalid = 1'b0;
`ifdef ADC_CAPTURE_DECIMATE_EN
        checks++;
        if (pulses != 1 || done_at != 6) begin errors++; $display("FAIL dec_done got pulses=%0d at %0d exp 1 at 6", pulses, done_at); end
        exp_words = '{hdr(64'd5001, 16'd3, 8'd2), 128'd6002, 128'd6005, 128'd6008};
`else
        checks++;
        if (pulses != 1 || done_at != 2) begin errors++; $display("FAIL dec_done got pulses=%0d at %0d exp 1 at 2", pulses, done_at); end
        exp_words = '{hdr(64'd5001, 16'd3, 8'd0), 128'd6002, 128'd6003, 128'd6004};
`endif
        drain(exp_words, "dec");
    endtask

    task automatic test_overflow();
        logic [127:0] exp_words [$];
        counter = 64'd2000;
        s_axis_tvalid = 1'b1;
        send_cmd(64'd2001, 16'd10, 8'd0);
        tick();
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 7) begin
                checks++;
                if (overflow_error !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", overflow_error); end
            end
            if (i == 8) begin
                checks++;
                if (overflow_error !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow_error); end
            end
        end
        checks++;
        if (capture_done !== 1'b1) begin errors++; $display("FAIL ovf_done got %b exp 1", capture_done); end
        s_axis_tvalid = 1'b0;
        exp_words = '{hdr(64'd2001, 16'd10, 8'd0), 128'd3002, 128'd3003, 128'd3004,
                      128'd3005, 128'd3006, 128'd3007, 128'd3008};
        drain(exp_words, "ovf");
    endtask

    task automatic test_flush();
        logic [127:0] exp_words [$];
        logic [63:0] start;
        int pulses = 0;
        counter = 64'd4000;
        s_axis_tvalid = 1'b1;
        send_cmd(64'd4001, 16'd100, 8'd0);
        tick();
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        if (capture_done === 1'b1) pulses++;
        checks++;
        if (empty !== 1'b1 || busy !== 1'b0 || cmd_full !== 1'b0) begin
            errors++; $display("FAIL flush_state got empty=%b busy=%b cmd_full=%b exp 1 0 0", empty, busy, cmd_full);
        end
        checks++;
        if (overflow_error !== 1'b1) begin errors++; $display("FAIL flush_keeps_ovf got %b exp 1", overflow_error); end
        repeat (3) begin
            tick();
            if (capture_done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL flush_no_done got %0d exp 0", pulses); end
        start = counter + 64'd1;
        send_cmd(start, 16'd1, 8'd0);
        tick();
        tick();
        checks++;
        if (capture_done !== 1'b1) begin errors++; $display("FAIL flush_next_done got %b exp 1", capture_done); end
        s_axis_tvalid = 1'b0;
        exp_words = '{hdr(start, 16'd1, 8'd0), {64'd0, start + 64'd1001}};
        drain(exp_words, "flush_next");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_late();
        test_gapped();
        test_decimation();
        test_overflow();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
